// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the ram_cache data port between the core load/store path (port 0)
// and a secondary master (port 1). One access in flight at a time, fixed read latency.
module dmem_arbiter #(
  parameter int unsigned Data_Width  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [Data_Width-1:0] addr0,
  input  logic [Data_Width-1:0] wdata0,
  input  logic [1:0]            type0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [Data_Width-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [Data_Width-1:0] addr1,
  input  logic [Data_Width-1:0] wdata1,
  input  logic [1:0]            type1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [Data_Width-1:0] rdata1,
  output logic [Data_Width-1:0] mem_A,
  output logic                  mem_WE,
  output logic [Data_Width-1:0] mem_WD,
  output logic [1:0]            mem_dataType,
  input  logic [Data_Width-1:0] mem_RD,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

  localparam logic [2:0] LatInit = 3'(MEM_LATENCY);

  state_e     state_q;
  logic       last_q;
  logic [2:0] cnt_q;
  logic       lat_we_q;
  logic       lat_port_q;

  logic any_req;
  logic win;
  logic done;

  // Tie goes to the port that did not win last time.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) win = ~last_q;
    else              win = req1;
  end

  always_comb begin
    done = 1'b0;
    if (state_q == StAccess && MEM_LATENCY == 0) done = 1'b1;
    if (state_q == StWait && cnt_q == 3'd1)      done = 1'b1;
  end

  assign gnt0   = (state_q == StIdle) && !rst && any_req && !win;
  assign gnt1   = (state_q == StIdle) && !rst && any_req && win;
  assign mem_WE = (state_q == StAccess) && lat_we_q;
  assign busy   = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_q       <= 1'b1;
      cnt_q        <= 3'd0;
      lat_we_q     <= 1'b0;
      lat_port_q   <= 1'b0;
      mem_A        <= '0;
      mem_WD       <= '0;
      mem_dataType <= 2'b00;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            mem_A        <= win ? addr1 : addr0;
            mem_WD       <= win ? wdata1 : wdata0;
            mem_dataType <= win ? type1 : type0;
            lat_we_q     <= win ? we1 : we0;
            lat_port_q   <= win;
            last_q       <= win;
            state_q      <= StAccess;
          end
        end
        StAccess: begin
          cnt_q   <= LatInit;
          state_q <= (MEM_LATENCY == 0) ? StIdle : StWait;
        end
        StWait: begin
          if (cnt_q == 3'd1) state_q <= StIdle;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        default: state_q <= StIdle;
      endcase
      // Response is registered: rvalid and rdata appear the cycle after sampling.
      if (done) begin
        if (lat_port_q) begin
          rvalid1 <= 1'b1;
          if (!lat_we_q) rdata1 <= mem_RD;
        end else begin
          rvalid0 <= 1'b1;
          if (!lat_we_q) rdata0 <= mem_RD;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle table against a MEM_LATENCY=1 instance, plus a short
// hand-written sequence against a MEM_LATENCY=0 instance.
module tb_dmem_arbiter;

  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] AB = 32'h0000_00AB;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A (latency 1)
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [1:0]  type0, type1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;
  logic [1:0]  mem_type;

  assign mem_rd = (mem_a == 32'h10) ? DB : {16'hCAFE, mem_a[15:0]};

  dmem_arbiter #(.Data_Width(32), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .type0(type0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .type1(type1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_A(mem_a), .mem_WE(mem_we), .mem_WD(mem_wd), .mem_dataType(mem_type),
    .mem_RD(mem_rd), .busy(busy)
  );

  // Instance B (latency 0, combinational read)
  logic        req0b, req1b;
  logic [31:0] addr0b;
  logic        gnt0b, gnt1b, rvalid0b, rvalid1b, mem_web, busyb;
  logic [31:0] rdata0b, rdata1b, mem_ab, mem_wdb, mem_rdb;
  logic [1:0]  mem_typeb;

  assign mem_rdb = (mem_ab == 32'h100) ? 32'h1234_5678 : {16'hBEEF, mem_ab[15:0]};

  dmem_arbiter #(.Data_Width(32), .MEM_LATENCY(0)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0b), .we0(1'b0), .addr0(addr0b), .wdata0(32'h0), .type0(2'b00),
    .gnt0(gnt0b), .rvalid0(rvalid0b), .rdata0(rdata0b),
    .req1(req1b), .we1(1'b0), .addr1(32'h0), .wdata1(32'h0), .type1(2'b00),
    .gnt1(gnt1b), .rvalid1(rvalid1b), .rdata1(rdata1b),
    .mem_A(mem_ab), .mem_WE(mem_web), .mem_WD(mem_wdb), .mem_dataType(mem_typeb),
    .mem_RD(mem_rdb), .busy(busyb)
  );

  typedef struct {
    logic        rst;
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic        w1;
    logic [31:0] a1;
    logic [1:0]  t1;
    logic [5:0]  flags;  // {gnt0, gnt1, rvalid0, rvalid1, busy, mem_WE}
    logic [31:0] ma;
    logic [31:0] mwd;
    logic [1:0]  mty;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic vec_t v(input logic rst_v, input logic r0, input logic [31:0] a0,
                             input logic r1, input logic w1, input logic [31:0] a1,
                             input logic [1:0] t1, input logic [5:0] flags,
                             input logic [31:0] ma, input logic [31:0] mwd,
                             input logic [1:0] mty, input logic [31:0] rd0,
                             input logic [31:0] rd1);
    vec_t x;
    x.rst = rst_v; x.r0 = r0; x.a0 = a0; x.r1 = r1; x.w1 = w1; x.a1 = a1; x.t1 = t1;
    x.flags = flags; x.ma = ma; x.mwd = mwd; x.mty = mty; x.rd0 = rd0; x.rd1 = rd1;
    return x;
  endfunction

  function automatic logic [31:0] cf(input logic [31:0] a);
    return {16'hCAFE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = W0; type0 = 2'b10;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = AB; type1 = 2'b00;
    req0b = 0; req1b = 0; addr0b = 0;

    // Single read, then a port 1 byte write
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000000, 0,     0,  2'b00, 0,  0));
    vq.push_back(v(0, 1, 'h10,  0, 0, 0,     2'b00, 6'b100000, 0,     0,  2'b00, 0,  0));
    vq.push_back(v(0, 0, 'h10,  0, 0, 0,     2'b00, 6'b000010, 'h10,  W0, 2'b10, 0,  0));
    vq.push_back(v(0, 0, 'h10,  0, 0, 0,     2'b00, 6'b000010, 'h10,  W0, 2'b10, 0,  0));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b001000, 'h10,  W0, 2'b10, DB, 0));
    vq.push_back(v(0, 0, 0,     1, 1, 'h20,  2'b01, 6'b010000, 'h10,  W0, 2'b10, DB, 0));
    vq.push_back(v(0, 0, 0,     0, 1, 'h99,  2'b11, 6'b000011, 'h20,  AB, 2'b01, DB, 0));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000010, 'h20,  AB, 2'b01, DB, 0));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000100, 'h20,  AB, 2'b01, DB, 0));
    // Both ports requesting continuously: grants alternate 0,1,0,1
    vq.push_back(v(0, 1, 'h40,  1, 0, 'h50,  2'b00, 6'b100000, 'h20,  AB, 2'b01, DB, 0));
    vq.push_back(v(0, 1, 'h44,  1, 0, 'h50,  2'b00, 6'b000010, 'h40,  W0, 2'b10, DB, 0));
    vq.push_back(v(0, 1, 'h44,  1, 0, 'h50,  2'b00, 6'b000010, 'h40,  W0, 2'b10, DB, 0));
    vq.push_back(v(0, 1, 'h44,  1, 0, 'h50,  2'b00, 6'b011000, 'h40,  W0, 2'b10, cf('h40), 0));
    vq.push_back(v(0, 1, 'h44,  1, 0, 'h54,  2'b00, 6'b000010, 'h50,  AB, 2'b00, cf('h40), 0));
    vq.push_back(v(0, 1, 'h44,  1, 0, 'h54,  2'b00, 6'b000010, 'h50,  AB, 2'b00, cf('h40), 0));
    vq.push_back(v(0, 1, 'h44,  1, 0, 'h54,  2'b00, 6'b100100, 'h50,  AB, 2'b00, cf('h40),
                   cf('h50)));
    vq.push_back(v(0, 1, 'h44,  1, 0, 'h54,  2'b00, 6'b000010, 'h44,  W0, 2'b10, cf('h40),
                   cf('h50)));
    vq.push_back(v(0, 1, 'h44,  1, 0, 'h54,  2'b00, 6'b000010, 'h44,  W0, 2'b10, cf('h40),
                   cf('h50)));
    vq.push_back(v(0, 1, 'h44,  1, 0, 'h54,  2'b00, 6'b011000, 'h44,  W0, 2'b10, cf('h44),
                   cf('h50)));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000010, 'h54,  AB, 2'b00, cf('h44),
                   cf('h50)));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000010, 'h54,  AB, 2'b00, cf('h44),
                   cf('h50)));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000100, 'h54,  AB, 2'b00, cf('h44),
                   cf('h54)));
    // Port 1 arrives during port 0's access: granted alongside rvalid0
    vq.push_back(v(0, 1, 'h60,  0, 0, 0,     2'b00, 6'b100000, 'h54,  AB, 2'b00, cf('h44),
                   cf('h54)));
    vq.push_back(v(0, 1, 'h60,  1, 0, 'h70,  2'b00, 6'b000010, 'h60,  W0, 2'b10, cf('h44),
                   cf('h54)));
    vq.push_back(v(0, 1, 'h60,  1, 0, 'h70,  2'b00, 6'b000010, 'h60,  W0, 2'b10, cf('h44),
                   cf('h54)));
    vq.push_back(v(0, 1, 'h60,  1, 0, 'h70,  2'b00, 6'b011000, 'h60,  W0, 2'b10, cf('h60),
                   cf('h54)));
    vq.push_back(v(0, 1, 'h60,  0, 0, 0,     2'b00, 6'b000010, 'h70,  AB, 2'b00, cf('h60),
                   cf('h54)));
    vq.push_back(v(0, 1, 'h60,  0, 0, 0,     2'b00, 6'b000010, 'h70,  AB, 2'b00, cf('h60),
                   cf('h54)));
    vq.push_back(v(0, 1, 'h60,  0, 0, 0,     2'b00, 6'b100100, 'h70,  AB, 2'b00, cf('h60),
                   cf('h70)));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000010, 'h60,  W0, 2'b10, cf('h60),
                   cf('h70)));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000010, 'h60,  W0, 2'b10, cf('h60),
                   cf('h70)));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b001000, 'h60,  W0, 2'b10, cf('h60),
                   cf('h70)));
    // Reset during WAIT aborts the read and restores port 0 priority
    vq.push_back(v(0, 1, 'h80,  0, 0, 0,     2'b00, 6'b100000, 'h60,  W0, 2'b10, cf('h60),
                   cf('h70)));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000010, 'h80,  W0, 2'b10, cf('h60),
                   cf('h70)));
    vq.push_back(v(1, 0, 0,     0, 0, 0,     2'b00, 6'b000010, 'h80,  W0, 2'b10, cf('h60),
                   cf('h70)));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000000, 0,     0,  2'b00, 0, 0));
    vq.push_back(v(0, 1, 'h90,  1, 0, 'hA0,  2'b00, 6'b100000, 0,     0,  2'b00, 0, 0));
    vq.push_back(v(0, 0, 0,     1, 0, 'hA0,  2'b00, 6'b000010, 'h90,  W0, 2'b10, 0, 0));
    vq.push_back(v(0, 0, 0,     1, 0, 'hA0,  2'b00, 6'b000010, 'h90,  W0, 2'b10, 0, 0));
    vq.push_back(v(0, 0, 0,     1, 0, 'hA0,  2'b00, 6'b011000, 'h90,  W0, 2'b10, cf('h90), 0));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000010, 'hA0,  AB, 2'b00, cf('h90), 0));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000010, 'hA0,  AB, 2'b00, cf('h90), 0));
    vq.push_back(v(0, 0, 0,     0, 0, 0,     2'b00, 6'b000100, 'hA0,  AB, 2'b00, cf('h90),
                   cf('hA0)));

    repeat (2) @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      cyc   = i;
      rst   = vq[i].rst;
      req0  = vq[i].r0;
      addr0 = vq[i].a0;
      req1  = vq[i].r1;
      we1   = vq[i].w1;
      addr1 = vq[i].a1;
      type1 = vq[i].t1;
      #1;
      chk("gnt0",     32'(gnt0),     32'(vq[i].flags[5]));
      chk("gnt1",     32'(gnt1),     32'(vq[i].flags[4]));
      chk("rvalid0",  32'(rvalid0),  32'(vq[i].flags[3]));
      chk("rvalid1",  32'(rvalid1),  32'(vq[i].flags[2]));
      chk("busy",     32'(busy),     32'(vq[i].flags[1]));
      chk("mem_WE",   32'(mem_we),   32'(vq[i].flags[0]));
      chk("mem_A",    mem_a,         vq[i].ma);
      chk("mem_WD",   mem_wd,        vq[i].mwd);
      chk("mem_type", 32'(mem_type), 32'(vq[i].mty));
      chk("rdata0",   rdata0,        vq[i].rd0);
      chk("rdata1",   rdata1,        vq[i].rd1);
    end

    // Zero-latency instance: read completes two cycles after grant, back-to-back grant on rvalid
    cyc = 1000;
    @(negedge clk);
    req0b = 1; addr0b = 32'h100;
    #1;
    chk("l0_gnt_t0",    32'(gnt0b),    32'd1);
    chk("l0_busy_t0",   32'(busyb),    32'd0);
    chk("l0_rvalid_t0", 32'(rvalid0b), 32'd0);
    cyc++;
    @(negedge clk);
    addr0b = 32'h104;
    #1;
    chk("l0_busy_t1",   32'(busyb),    32'd1);
    chk("l0_gnt_t1",    32'(gnt0b),    32'd0);
    chk("l0_memA_t1",   mem_ab,        32'h100);
    chk("l0_memWE_t1",  32'(mem_web),  32'd0);
    cyc++;
    @(negedge clk);
    #1;
    chk("l0_rvalid_t2", 32'(rvalid0b), 32'd1);
    chk("l0_rdata_t2",  rdata0b,       32'h1234_5678);
    chk("l0_gnt_t2",    32'(gnt0b),    32'd1);
    chk("l0_busy_t2",   32'(busyb),    32'd0);
    chk("l0_rvalid1",   32'(rvalid1b), 32'd0);
    cyc++;
    @(negedge clk);
    req0b = 0;
    #1;
    chk("l0_busy_t3",   32'(busyb),    32'd1);
    chk("l0_memA_t3",   mem_ab,        32'h104);
    cyc++;
    @(negedge clk);
    #1;
    chk("l0_rvalid_t4", 32'(rvalid0b), 32'd1);
    chk("l0_rdata_t4",  rdata0b,       32'hBEEF_0104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port of ram_cache (A / WE / WD / dataType / RD) between two requesters.
- Port 0 is the core load/store path (ALU result address, rs2 write data). Port 1 is a secondary master (debug/loader).
- Round-robin arbitration, one outstanding access at a time.
- Per-port req/gnt/rvalid handshake with a fixed memory read latency.

Parameters:
Data_Width, 32, width of address, write data and read data
MEM_LATENCY, 1, cycles from the ACCESS cycle to valid mem_RD; legal range 0..7 (0 = combinational read)

Ports:
clk  in  1  clock
rst  in  1  reset
req0  in  1  port 0 request
we0  in  1  port 0 write (1) / read (0)
addr0  in  Data_Width  port 0 byte address
wdata0  in  Data_Width  port 0 write data
type0  in  2  port 0 access size: 00 word, 01 byte, 10 halfword
gnt0  out  1  port 0 request accepted
rvalid0  out  1  port 0 access complete
rdata0  out  Data_Width  port 0 read data
req1, we1, addr1, wdata1, type1, gnt1, rvalid1, rdata1: same as port 0, for port 1
mem_A  out  Data_Width  to ram_cache A
mem_WE  out  1  to ram_cache WE
mem_WD  out  Data_Width  to ram_cache WD
mem_dataType  out  2  to ram_cache dataType
mem_RD  in  Data_Width  from ram_cache RD
busy  out  1  transaction in flight

Behaviour:
- Reset: one clock (clk); rst is synchronous and active-high. rst=1 at a rising edge forces:
  - state=IDLE, last=1 (port 0 wins the first tie).
  - gnt*, rvalid*, rdata*, mem_A, mem_WD, mem_dataType, mem_WE, busy all 0.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE:
  - If either req is high, select a winner. With one requester, that port wins. With both, the port != last wins.
  - gntX is combinational and high in that same IDLE cycle, for the winner only.
  - Register addr/wdata/we/type into the transaction latch and set last=X. Next state ACCESS.
  - No req: stay in IDLE.
- Requester rule: hold req and payload stable until the gnt cycle. Dropping req before gnt is legal and has no effect. A payload change after gnt is ignored.
- ACCESS (exactly 1 cycle):
  - mem_A, mem_WD, mem_dataType driven from the latch. mem_WE = latched we, in this cycle only.
  - Load latency counter with MEM_LATENCY. Next state WAIT, or IDLE directly if MEM_LATENCY=0 (see sampling).
- WAIT:
  - mem_WE=0 and mem_A held. Decrement counter.
  - Sample mem_RD at the end of the cycle where counter==1. Next state IDLE.
- Sampling point: end of cycle ACCESS+MEM_LATENCY. For MEM_LATENCY=0, sample at the end of ACCESS.
- Response:
  - rvalidX is a registered 1-cycle pulse in the cycle after sampling; state is IDLE in that cycle.
  - Reads: rdataX is updated with the sampled mem_RD in the same cycle and held until the next read completes on that port.
  - Writes: rvalidX pulses, rdataX unchanged.
  - The other port's rvalid/rdata never change.
- Timing (gnt at cycle T):
  - ACCESS at T+1, sample at end of T+1+L, rvalid at T+2+L.
  - A new gnt may coincide with the rvalid cycle.
  - Throughput: one access per L+2 cycles.
- Counter width: 3 bits (covers MEM_LATENCY ≤ 7).
- busy = (state != IDLE).
- mem_A, mem_WD and mem_dataType hold the last latched values while IDLE. mem_WE is 0 in every state except ACCESS.
- dataType 11 passes through unmodified; no checking.
- Reset mid-transaction (ACCESS or WAIT):
  - Abort; no rvalid is issued.
  - mem_WE=0 from the next cycle; state IDLE, last=1.
- Requests arriving while busy are not granted until IDLE. The losing port is guaranteed the next grant, so there is no starvation.

Test Plan:
1. MEM_LATENCY=1, after reset, req0 read addr0=0x00000010 at T, mem_RD model returns 0xDEADBEEF -> gnt0=1 at T; mem_A=0x10 at T+1..T+2; mem_WE=0 throughout; rvalid0=1 at T+3 with rdata0=0xDEADBEEF; busy=1 at T+1..T+2 only.
2. req0 and req1 both held high continuously from reset, 4 reads -> grant order 0,1,0,1; gnts at T, T+3, T+6, T+9; each rvalid goes only to the matching port.
3. req1 write, addr1=0x20, wdata1=0x000000AB, type1=01 -> mem_WE high for exactly 1 cycle (T+1) with mem_A=0x20, mem_WD=0xAB, mem_dataType=01; rvalid1 pulse at T+3; rdata1 keeps its previous value; rvalid0 stays 0.
4. req0 held continuously, req1 raised at T+1 during port 0's access -> gnt1 at T+3 (coincides with rvalid0), then gnt0 at T+6.
5. rst asserted for 1 cycle during WAIT of a port 0 read -> no rvalid0; busy=0, mem_WE=0 next cycle; a subsequent simultaneous req0/req1 grants port 0.
6. MEM_LATENCY=0, req0 read, mem_RD=0x12345678 combinational -> gnt0 at T, ACCESS at T+1, rvalid0 at T+2 with rdata0=0x12345678; a back-to-back req0 is granted at T+2.
